// File: rtl/shot_tracker.sv
// Shot tracker for a matrix-display battleship game: takes debounced fire presses,
// keeps hit/miss masks and the shot budget, and builds the blinking display image.
module shot_tracker #(
    parameter int M_DATA_WIDTH    = 35,
    parameter int M_COLUNE_SIZE   = 7,
    parameter int M_TOTAL_COLUNES = 5,
    parameter int MAX_SHOTS       = 15,
    parameter int BLINK_DIV       = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enableAttack,
    input  logic                    new_game,
    input  logic                    confirmAttack,
    input  logic [2:0]              x_coord_code,
    input  logic [2:0]              y_coord_code,
    input  logic [M_DATA_WIDTH-1:0] selected_map,
    output logic [M_DATA_WIDTH-1:0] matriz_data,
    output logic [1:0]              ledRgb,
    output logic [3:0]              shots_left,
    output logic                    game_over,
    output logic                    win
);

    typedef enum logic [1:0] {IDLE, READY, EVAL, DONE} state_t;

    localparam int IDX_W   = $clog2(M_DATA_WIDTH);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [1:0] LED_OFF    = 2'b00;
    localparam logic [1:0] LED_MISS   = 2'b01;
    localparam logic [1:0] LED_HIT    = 2'b10;
    localparam logic [1:0] LED_REJECT = 2'b11;

    state_t                  state, state_d;
    logic [M_DATA_WIDTH-1:0] hit_mask, hit_d;
    logic [M_DATA_WIDTH-1:0] miss_mask, miss_d;
    logic [3:0]              shots_d;
    logic [1:0]              led_d;
    logic                    win_d, over_d;
    logic [BLINK_W-1:0]      blink_cnt, blink_cnt_d;
    logic                    phase, phase_d;
    logic                    confirm_q, confirm_d;
    logic                    edge_q, edge_d;

    logic                    coord_valid;
    logic [IDX_W-1:0]        cell_idx;
    logic [M_DATA_WIDTH-1:0] cell_bit;
    logic                    cell_taken;

    // Decode the target into a one-hot cell; out-of-range coordinates decode to nothing.
    always_comb begin
        coord_valid = (int'(x_coord_code) < M_TOTAL_COLUNES) &&
                      (int'(y_coord_code) < M_COLUNE_SIZE);
        cell_idx    = IDX_W'(x_coord_code) * IDX_W'(M_COLUNE_SIZE) + IDX_W'(y_coord_code);
        cell_bit    = coord_valid ? (M_DATA_WIDTH'(1) << cell_idx) : '0;
        cell_taken  = (cell_bit & (hit_mask | miss_mask)) != '0;
    end

    // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d     = state;
        hit_d       = hit_mask;
        miss_d      = miss_mask;
        shots_d     = shots_left;
        led_d       = ledRgb;
        win_d       = win;
        over_d      = game_over;
        phase_d     = phase ^ (blink_cnt == BLINK_LAST);
        blink_cnt_d = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
        confirm_d   = confirmAttack;
        // Only a rise seen while armed counts; rises in IDLE, EVAL or DONE are lost.
        edge_d      = confirmAttack && !confirm_q && (state == READY);

        case (state)
            IDLE: if (enableAttack) state_d = READY;
            READY: begin
                if (!enableAttack)  state_d = IDLE;
                else if (edge_q)    state_d = EVAL;
            end
            EVAL: begin
                if (!coord_valid || cell_taken) begin
                    led_d = LED_REJECT;
                end else begin
                    if ((cell_bit & selected_map) != '0) begin
                        hit_d = hit_mask | cell_bit;
                        led_d = LED_HIT;
                    end else begin
                        miss_d = miss_mask | cell_bit;
                        led_d  = LED_MISS;
                    end
                    if (shots_left != '0) shots_d = shots_left - 4'd1;
                end
                win_d   = (selected_map != '0) && ((selected_map & ~hit_d) == '0);
                over_d  = win_d || (shots_d == '0);
                state_d = over_d ? DONE : READY;
            end
            DONE: state_d = DONE;
        endcase

        // A new game wipes everything, whatever else happens in the same cycle.
        if (new_game) begin
            state_d     = IDLE;
            hit_d       = '0;
            miss_d      = '0;
            shots_d     = 4'(MAX_SHOTS);
            led_d       = LED_OFF;
            win_d       = 1'b0;
            over_d      = 1'b0;
            phase_d     = 1'b0;
            blink_cnt_d = '0;
            confirm_d   = 1'b0;
            edge_d      = 1'b0;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_mask   <= '0;
            miss_mask  <= '0;
            shots_left <= 4'(MAX_SHOTS);
            ledRgb     <= LED_OFF;
            win        <= 1'b0;
            game_over  <= 1'b0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            confirm_q  <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            hit_mask   <= hit_d;
            miss_mask  <= miss_d;
            shots_left <= shots_d;
            ledRgb     <= led_d;
            win        <= win_d;
            game_over  <= over_d;
            blink_cnt  <= blink_cnt_d;
            phase      <= phase_d;
            confirm_q  <= confirm_d;
            edge_q     <= edge_d;
        end
    end

    // Misses blink during play; once the game ends the unsunk ships blink instead.
    always_comb begin
        matriz_data = hit_mask | (phase ? ((state == DONE) ? selected_map : miss_mask) : '0);
    end

endmodule
